// File: rtl/axi4_duth_noc_pkg.sv
// Shared helpers for the DUTH NoC router blocks.
package axi4_duth_noc_pkg;

  localparam int unsigned MAX_PORTS = 32;
  localparam int unsigned MAX_IDX_W = 5;

  // Index of the set bit in a one-hot vector; OR-reduction keeps it mux-free.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_PORTS); i++) begin
      if (vec[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_out_port_lock_rr_arbiter.sv
// Round-robin arbiter: the winner keeps top priority until update_pri moves it past
// the winner (packet end). With no request, priority holds.
module rr_arbiter #(
  parameter int N       = 4,
  parameter int PRI_RST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] update_pri,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0]  pri_q, pri_d;
  logic [IW-1:0]  win;
  logic           found;
  logic [2*N-1:0] req_rot_full;
  logic [N-1:0]   req_rot;
  logic [IW:0]    sum;

  always_comb begin
    req_rot_full = {req, req} >> pri_q;
    req_rot      = req_rot_full[N-1:0];
    found        = 1'b0;
    win          = '0;
    sum          = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, pri_q} + (IW+1)'(i);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        win   = sum[IW-1:0];
      end
    end
    grant = '0;
    for (int k = 0; k < N; k++) begin
      grant[k] = found && (win == IW'(k));
    end
  end

  always_comb begin
    pri_d = pri_q;
    if (|update_pri) begin
      pri_d = (win == IW'(N-1)) ? '0 : win + IW'(1);
    end else if (found) begin
      pri_d = win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pri_q <= IW'(PRI_RST);
    else     pri_q <= pri_d;
  end

endmodule

// File: rtl/noc_out_port_lock.sv
// Wormhole output port: round-robin per packet, locked to one input until its tail,
// feeding a 2-entry elastic buffer; in_ready depends only on registered occupancy.
module noc_out_port_lock
  import axi4_duth_noc_pkg::*;
#(
  parameter int N       = 4,
  parameter int DW      = 64,
  parameter int PRI_RST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic            out_ready
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCKED} lock_state_e;

  lock_state_e   state_q, state_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] slot_data_q [2];
  logic [DW-1:0] slot_data_d [2];
  logic          slot_last_q [2];
  logic          slot_last_d [2];

  logic [N-1:0]  req, grant, update_pri;
  logic          lock_valid, space, accept, pop, win_last;
  logic [DW-1:0] win_data;

  assign lock_valid = (state_q == LOCKED);
  assign req        = lock_valid ? (in_valid & (N'(1) << lock_idx_q)) : in_valid;
  // Gate with rst so nothing is offered while the buffer is being cleared.
  assign space      = (cnt_q < 2'd2) & ~rst;
  assign in_ready   = grant & {N{space}};
  assign accept     = |(in_valid & in_ready);
  assign win_last   = |(grant & in_last);
  assign update_pri = {N{accept}} & grant & in_last;

  assign out_valid  = (cnt_q != 2'd0);
  assign out_data   = slot_data_q[rd_ptr_q];
  assign out_last   = slot_last_q[rd_ptr_q];
  assign pop        = out_valid & out_ready;

  rr_arbiter #(.N(N), .PRI_RST(PRI_RST)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .update_pri (update_pri),
    .grant      (grant)
  );

  always_comb begin
    win_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) win_data = in_data[k*DW +: DW];
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      IDLE: if (accept && !win_last) begin
        state_d    = LOCKED;
        lock_idx_d = IW'(onehot_to_idx(MAX_PORTS'(grant)));
      end
      LOCKED: if (accept && win_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slot_data_d = slot_data_q;
    slot_last_d = slot_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (accept) begin
      slot_data_d[wr_ptr_q] = win_data;
      slot_last_d[wr_ptr_q] = win_last;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, accept} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_idx_q  <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      slot_data_q <= '{default: '0};
      slot_last_q <= '{default: 1'b0};
    end else begin
      state_q     <= state_d;
      lock_idx_q  <= lock_idx_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      slot_data_q <= slot_data_d;
      slot_last_q <= slot_last_d;
    end
  end

endmodule

// File: tb/tb_noc_out_port_lock.sv
// Directed bench for noc_out_port_lock (N=4, DW=64, PRI_RST=0).
module tb_noc_out_port_lock;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic [DW-1:0]   din [N];

  int checks   = 0;
  int failures = 0;

  assign in_data = {din[3], din[2], din[1], din[0]};

  always #5 clk = ~clk;

  noc_out_port_lock #(.N(N), .DW(DW), .PRI_RST(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
    for (int k = 0; k < N; k++) din[k] = '0;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data, 64'd0);
    chk("rst_out_last",  64'(out_last), 64'd0);
    in_valid = 4'hF; in_last = 4'hF;
    for (int k = 0; k < N; k++) din[k] = 64'h10 + 64'(k);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rr_first_ready", 64'(in_ready), 64'b0001);
    chk("rr_first_empty", 64'(out_valid), 64'd0);

    // Single-flit packets from all inputs: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      chk("rr_out_valid", 64'(out_valid), 64'd1);
      chk("rr_out_data",  out_data, 64'h10 + 64'(i % 4));
      chk("rr_out_last",  64'(out_last), 64'd1);
      chk("rr_in_ready",  64'(in_ready), 64'(4'b0001 << ((i + 1) % 4)));
      if (i == 4) in_valid = '0;
    end
    next_cyc();
    chk("rr_drain", 64'(out_valid), 64'd0);

    // 4-flit packet from input 2 with inputs 0 and 3 competing (priority at 1)
    in_valid = 4'b1101; in_last = 4'b1001;
    din[0] = 64'h30; din[3] = 64'h33; din[2] = 64'h20;
    #1;
    chk("pkt_ready0", 64'(in_ready), 64'b0100);
    for (int s = 1; s < 4; s++) begin
      next_cyc();
      din[2] = 64'h20 + 64'(s);
      in_last[2] = (s == 3);
      #1;
      chk("pkt_locked_ready", 64'(in_ready), 64'b0100);
      chk("pkt_out_data", out_data, 64'h20 + 64'(s - 1));
      chk("pkt_out_last", 64'(out_last), 64'd0);
    end
    next_cyc();
    in_valid = 4'b1001;
    #1;
    chk("pkt_next_is_3", 64'(in_ready), 64'b1000);
    chk("pkt_tail_data", out_data, 64'h23);
    chk("pkt_tail_last", 64'(out_last), 64'd1);
    next_cyc();
    in_valid = '0;
    #1;
    chk("pkt_in3_data",  out_data, 64'h33);
    chk("pkt_in3_valid", 64'(out_valid), 64'd1);
    next_cyc();
    chk("pkt_drain", 64'(out_valid), 64'd0);

    // Backpressure: out_ready low for 5 cycles, input 1 streaming
    out_ready = 1'b0; in_valid = 4'b0010; in_last = 4'hF; din[1] = 64'h50;
    #1;
    chk("bp_ready_g0", 64'(in_ready), 64'b0010);
    next_cyc();
    din[1] = 64'h51;
    #1;
    chk("bp_ready_g1", 64'(in_ready), 64'b0010);
    chk("bp_data_g1", out_data, 64'h50);
    next_cyc();
    din[1] = 64'h52;
    #1;
    chk("bp_full_ready", 64'(in_ready), 64'b0000);
    for (int g = 0; g < 2; g++) begin
      next_cyc();
      #1;
      chk("bp_full_ready", 64'(in_ready), 64'b0000);
      chk("bp_full_valid", 64'(out_valid), 64'd1);
      chk("bp_stable_data", out_data, 64'h50);
    end
    next_cyc();
    out_ready = 1'b1;
    #1;
    chk("bp_full_no_comb", 64'(in_ready), 64'b0000);
    chk("bp_rel_data0", out_data, 64'h50);
    next_cyc();
    #1;
    chk("bp_rel_data1", out_data, 64'h51);
    chk("bp_rel_ready", 64'(in_ready), 64'b0010);
    next_cyc();
    in_valid = '0;
    #1;
    chk("bp_rel_data2", out_data, 64'h52);
    next_cyc();
    chk("bp_drain", 64'(out_valid), 64'd0);

    // Locked input 1 idles mid-packet while input 0 waits
    in_valid = 4'b0010; in_last = 4'b0001; din[1] = 64'h60; din[0] = 64'h70;
    #1;
    chk("hold_ready0", 64'(in_ready), 64'b0010);
    next_cyc();
    in_valid = 4'b0011; din[1] = 64'h61;
    #1;
    chk("hold_locked", 64'(in_ready), 64'b0010);
    chk("hold_data0", out_data, 64'h60);
    next_cyc();
    in_valid = 4'b0001;
    #1;
    chk("hold_gap_ready", 64'(in_ready), 64'b0000);
    chk("hold_data1", out_data, 64'h61);
    for (int g = 0; g < 2; g++) begin
      next_cyc();
      #1;
      chk("hold_gap_ready", 64'(in_ready), 64'b0000);
      chk("hold_gap_idle", 64'(out_valid), 64'd0);
    end
    next_cyc();
    in_valid = 4'b0011; din[1] = 64'h62; in_last = 4'b0011;
    #1;
    chk("hold_tail_ready", 64'(in_ready), 64'b0010);
    next_cyc();
    in_valid = 4'b0001;
    #1;
    chk("hold_in0_ready", 64'(in_ready), 64'b0001);
    chk("hold_tail_data", out_data, 64'h62);
    chk("hold_tail_last", 64'(out_last), 64'd1);
    next_cyc();
    in_valid = '0;
    #1;
    chk("hold_in0_data", out_data, 64'h70);
    next_cyc();
    chk("hold_drain", 64'(out_valid), 64'd0);

    // Reset while input 2 is locked with a full buffer
    out_ready = 1'b0; in_valid = 4'b0100; in_last = '0; din[2] = 64'h80;
    #1;
    chk("mrst_ready0", 64'(in_ready), 64'b0100);
    next_cyc();
    din[2] = 64'h81;
    #1;
    chk("mrst_ready1", 64'(in_ready), 64'b0100);
    next_cyc();
    in_valid = 4'b0101; din[0] = 64'h90; in_last = 4'b0001;
    #1;
    chk("mrst_full_ready", 64'(in_ready), 64'b0000);
    chk("mrst_full_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_out_data",  out_data, 64'd0);
    chk("mrst_in_ready",  64'(in_ready), 64'b0000);
    next_cyc();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("mrst_pri_rst_wins", 64'(in_ready), 64'b0001);
    next_cyc();
    in_valid = '0;
    #1;
    chk("mrst_out_data_in0", out_data, 64'h90);
    chk("mrst_out_valid_in0", 64'(out_valid), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_out_port_lock.md
# noc_out_port_lock

Wormhole output port of a DUTH NoC router: collects flits from N input ports and forwards them, one packet at a time, into a 2-entry elastic output buffer. Arbitration is round-robin; once a packet's first flit is accepted the port is locked to that input until its last flit is accepted. Sits between the per-input buffers and the output link/next router, and is the sole consumer of the output arbiter's grant.

## Interface
- N, 4, number of input ports (≥2).
- DW, 64, flit payload width.
- PRI_RST, 0, input holding highest priority after reset (0..N-1).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  N  flit valid per input.
- in_data  in  N*DW  flit payload; input k occupies bits [k*DW +: DW].
- in_last  in  N  tail-flit marker per input.
- in_ready  out  N  flit accepted from input k when in_valid[k] & in_ready[k].
- out_valid  out  1  output flit valid.
- out_data  out  DW  output payload.
- out_last  out  1  output tail marker.
- out_ready  in  1  downstream accept.

## Operation
- State: lock_valid (1b), lock_idx (clog2(N) b), buffer count cnt (0..2), two slots {data,last}, read pointer, write pointer.
- Arbiter request: lock_valid ? (in_valid & onehot(lock_idx)) : in_valid.
- space = (cnt < 2); in_ready[k] = grant[k] & space; at most one in_ready bit set.
- accept = |(in_valid & in_ready); winner k is written to the slot at the write pointer, together with in_last[k].
- update_pri[k] = accept & grant[k] & in_last[k]: priority moves to k+1 (wrapping N-1 -> 0) only at packet end; otherwise the winner keeps top priority.
- Lock FSM: IDLE (lock_valid=0) -> LOCKED(k) on acceptance of a non-last flit from k. LOCKED(k) -> IDLE on acceptance of a last flit from k. A single-flit packet (last on first flit) never enters LOCKED. While LOCKED, other inputs' in_ready stay 0 regardless of in_valid.
- Buffer: out_valid = (cnt != 0); out_data/out_last from slot at read pointer. Pop when out_valid & out_ready. cnt' = cnt + accept - pop; push and pop in the same cycle at cnt=2 is impossible (no space), at cnt=1 or 0 both pointers advance (0: push only).
- Pointers are 1 bit, wrap 1 -> 0.
- in_ready does not depend combinationally on out_ready (space derives from registered cnt).

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, cnt 0, lock_valid 0, lock_idx 0, arbiter priority at PRI_RST. in_ready is 0 while rst is high (cnt-based space is forced low during reset).
- Latency: flit accepted in cycle t appears on out_* in cycle t+1 if buffer was empty.
- Throughput: 1 flit/cycle sustained with out_ready held high; back-to-back packets from different inputs with no bubble (arbitration for the next packet happens in the cycle the previous tail is accepted+1).
- Buffer full (cnt=2): all in_ready 0; lock and priority unchanged except priority re-pointing to the current grantee (same arbitration outcome).
- Locked input deasserts in_valid mid-packet: port idles, lock held, no other input served.
- rst asserted mid-packet: buffer contents discarded, lock dropped, priority back to PRI_RST immediately (asynchronous).

## Structure
- Package axi4_duth_noc_pkg: add function onehot_to_idx(N-bit vector) for lock_idx capture; no new typedefs.
- One sub-module: rr_arbiter (N, PRI_RST) instantiated for request/grant/update_pri; lock FSM and 2-slot buffer coded inline.

## Test plan
- Reset release, N=4, PRI_RST=0, all in_valid=1, single-flit packets, out_ready=1 -> outputs from inputs 0,1,2,3,0 on consecutive cycles starting one cycle after first accept.
- Input 2 sends 4-flit packet while inputs 0,3 valid -> 4 consecutive flits from 2, in_ready[0]=in_ready[3]=0 throughout, then input 3 served next.
- out_ready=0 for 5 cycles, input 1 streaming -> exactly 2 flits accepted, in_ready[1]=0 afterwards, out_data stable; release -> flits in order, none lost or duplicated.
- Locked input 1 drops in_valid for 3 cycles mid-packet, input 0 valid -> no flit from input 0 until input 1 tail accepted.
- rst pulsed while input 2 locked with cnt=2 -> out_valid 0 same cycle, after release input 0 (PRI_RST) wins first.
- Random valid/ready, N=4, 10k flits -> per-input packet order preserved, packets never interleaved on output, grant shares within ±1 packet under full load.
